mic1_uart_io: RTL

- Memory-mapped UART I/O bridge between the mic1 data-memory bus and the uart_rx/uart_tx pair.
- Replaces the single-byte receive register in the SoC top with two buffers:
  - an RX FIFO filled by uart_rx;
  - a TX FIFO filled by core writes and drained into uart_tx by a handshake FSM.
- The top level muxes bus_rdata over main-memory read data when rdata_sel is high, and gates the core run enable with stall.

---
 rtl/mic1_io_pkg.sv | 23 ++
 rtl/mic1_io_fifo.sv | 65 ++++++
 rtl/mic1_uart_io.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mic1_io_pkg.sv
// mic1_io_pkg: shared definitions for the mic1 UART I/O bridge.
//   - default I/O addresses (byte data port, status word)
//   - bit positions inside the status word (used when MIC1_UART_IO_STATUS_EN is defined)
//   - tx_state_t: states of the transmit handshake FSM
package mic1_io_pkg;

  localparam logic [31:0] DATA_ADDR_DEF   = 32'hFFFF_FFFD;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'hFFFF_FFFC;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_DRAINED   = 2;
  localparam int ST_RX_OVERFLOW  = 3;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_BUSY  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/mic1_io_fifo.sv
// mic1_io_fifo: synchronous FIFO with a first-word-fall-through head.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push, din  write request and data; accepted when not full, or when full
//              and a pop is accepted in the same cycle
//   pop        read request; ignored when empty
//   dout       current head (valid while empty == 0)
//   count      number of stored entries, $clog2(DEPTH)+1 bits
//   full       count == DEPTH
//   empty      count == 0
// DEPTH must be a power of two >= 2 so that the pointers wrap naturally.
module mic1_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mic1_uart_io.sv
// mic1_uart_io: memory-mapped UART I/O bridge for the mic1 data-memory bus.
// An RX FIFO collects bytes from uart_rx; reads of DATA_ADDR pop it (0 = no byte).
// Writes to DATA_ADDR queue bytes into a TX FIFO that a handshake FSM drains
// into uart_tx. stall flags a full TX FIFO so the SoC can hold the core.
// Optional feature macro: MIC1_UART_IO_STATUS_EN -- decodes STATUS_ADDR and
// keeps a sticky RX overflow flag.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus_en                        core run qualifier for all bus strobes
//   bus_addr/read/write/wdata     core data bus (only wdata[7:0] used)
//   bus_rdata, rdata_sel          registered read data and its override select
//   stall                         TX FIFO full
//   rx_data, rx_done              byte and strobe from uart_rx
//   tx_data, tx_start, tx_busy    handshake with uart_tx
//   tx_state                      transmit FSM state (debug)
// Handshake with uart_tx: tx_start rises with tx_data valid and stays high
// until tx_busy is seen high; the next byte is offered only after tx_busy
// has fallen and the FSM has spent one cycle in T_IDLE.
module mic1_uart_io
  import mic1_io_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
`ifdef MIC1_UART_IO_STATUS_EN
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
`endif
  parameter int          RX_DEPTH    = 8,
  parameter int          TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en,
  input  logic [31:0] bus_addr,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        rdata_sel,
  output logic        stall,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output tx_state_t   tx_state
);

  logic [7:0]                rx_dout;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                      rx_full;
  logic                      rx_empty;
  logic                      rx_pop;

  logic [7:0]                tx_dout;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                      tx_full;
  logic                      tx_empty;
  logic                      tx_push;
  logic                      tx_pop;

  logic rd_data_hit;
  logic wr_data_hit;
  logic unused_ok;

  assign rd_data_hit = bus_en && bus_read  && (bus_addr == DATA_ADDR);
  assign wr_data_hit = bus_en && bus_write && (bus_addr == DATA_ADDR);

  assign rx_pop  = rd_data_hit && !rx_empty;
  // Writes into a full TX FIFO are dropped even if the FSM pops that cycle.
  assign tx_push = wr_data_hit && !tx_full;
  assign tx_pop  = (tx_state == T_IDLE) && !tx_empty;
  assign stall   = tx_full;

  mic1_io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_done),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  mic1_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus_wdata[7:0]),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

`ifdef MIC1_UART_IO_STATUS_EN
  logic        rd_status_hit;
  logic        rx_overflow;
  logic        overflow_set;
  logic [31:0] status_word;

  assign rd_status_hit = bus_en && bus_read && (bus_addr == STATUS_ADDR);
  assign overflow_set  = rx_done && rx_full && !rx_pop;

  always_comb begin
    status_word                          = '0;
    status_word[ST_RX_NONEMPTY]          = !rx_empty;
    status_word[ST_TX_FULL]              = tx_full;
    status_word[ST_TX_DRAINED]           = tx_empty && (tx_state == T_IDLE);
    status_word[ST_RX_OVERFLOW]          = rx_overflow;
    status_word[ST_RX_COUNT_LSB +: 8]    = 8'(rx_count);
    status_word[ST_TX_COUNT_LSB +: 8]    = 8'(tx_count);
  end

  // Sticky flag: a new overflow in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
    end else if (overflow_set) begin
      rx_overflow <= 1'b1;
    end else if (rd_status_hit) begin
      rx_overflow <= 1'b0;
    end
  end

  assign unused_ok = ^bus_wdata[31:8];
`else
  logic rd_status_hit;
  logic [31:0] status_word;
  assign rd_status_hit = 1'b0;
  assign status_word   = '0;
  assign unused_ok     = ^{bus_wdata[31:8], rx_count, tx_count, rx_full};
`endif

  // Read path: one cycle of latency, rdata_sel marks the cycle the data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_sel <= 1'b0;
      bus_rdata <= '0;
    end else begin
      rdata_sel <= rd_data_hit || rd_status_hit;
      if (rd_data_hit) begin
        bus_rdata <= rx_empty ? 32'd0 : {24'd0, rx_dout};
      end else if (rd_status_hit) begin
        bus_rdata <= status_word;
      end
    end
  end

  // Transmit handshake FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (!tx_empty) begin
            tx_data  <= tx_dout;
            tx_start <= 1'b1;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            tx_state <= T_BUSY;
          end
        end
        T_BUSY: begin
          if (!tx_busy) begin
            tx_state <= T_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule
